// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with stall, flush and forwarding-hit flags
// Optional retire/bubble performance counters are enabled by defining MEMWB_PERF_EN.
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int R0_ZERO = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc_plus,
  input  logic [1:0]        in_wb_sel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] src_a,
  input  logic [REG_AW-1:0] src_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc_plus,
  output logic [1:0]        out_wb_sel,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [CNT_W-1:0]  retired_count,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic R0Z = (R0_ZERO != 0);

  logic              r_valid;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_mem_data;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc_plus;
  logic [1:0]        r_wb_sel;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;

  logic w_bubble;
  logic w_load_reg_write;

  // An invalid MEM slot is treated exactly like a flush: the whole bundle zeroes.
  assign w_bubble         = flush | ~in_valid;
  assign w_load_reg_write = in_valid & in_reg_write & ~(R0Z & (in_rd == '0));

  always_ff @(posedge clk) begin
    if (rst || (!stall && w_bubble) || flush) begin
      r_valid      <= 1'b0;
      r_alu_result <= '0;
      r_mem_data   <= '0;
      r_imm        <= '0;
      r_pc_plus    <= '0;
      r_wb_sel     <= 2'b00;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
    end else if (!stall) begin
      r_valid      <= 1'b1;
      r_alu_result <= in_alu_result;
      r_mem_data   <= in_mem_data;
      r_imm        <= in_imm;
      r_pc_plus    <= in_pc_plus;
      r_wb_sel     <= in_wb_sel;
      r_rd         <= in_rd;
      r_reg_write  <= w_load_reg_write;
    end
  end

  assign out_valid      = r_valid;
  assign out_alu_result = r_alu_result;
  assign out_mem_data   = r_mem_data;
  assign out_imm        = r_imm;
  assign out_pc_plus    = r_pc_plus;
  assign out_wb_sel     = r_wb_sel;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_reg_write;

  assign fwd_a_hit = r_valid & r_reg_write & (r_rd == src_a) & ~(R0Z & (src_a == '0));
  assign fwd_b_hit = r_valid & r_reg_write & (r_rd == src_b) & ~(R0Z & (src_b == '0));

`ifdef MEMWB_PERF_EN
  logic [CNT_W-1:0] r_retired_count;
  logic [CNT_W-1:0] r_bubble_count;

  // Counters account for whatever leaves WB on a non-stalled edge and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_count <= '0;
      r_bubble_count  <= '0;
    end else if (!stall) begin
      if (r_valid && (r_retired_count != '1))
        r_retired_count <= r_retired_count + 1'b1;
      if (!r_valid && (r_bubble_count != '1))
        r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign retired_count = r_retired_count;
  assign bubble_count  = r_bubble_count;
`else
  assign retired_count = '0;
  assign bubble_count  = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_write;
  logic [15:0] in_alu_result, in_mem_data, in_imm, in_pc_plus;
  logic [1:0]  in_wb_sel;
  logic [3:0]  in_rd, src_a, src_b;
  logic        out_valid, out_reg_write, fwd_a_hit, fwd_b_hit;
  logic [15:0] out_alu_result, out_mem_data, out_imm, out_pc_plus;
  logic [1:0]  out_wb_sel;
  logic [3:0]  out_rd;
  logic [31:0] retired_count, bubble_count;

  int n_pass = 0;
  int n_total = 0;

  logic [71:0] obs;
  assign obs = {out_valid, out_reg_write, out_wb_sel, out_rd,
                out_alu_result, out_mem_data, out_imm, out_pc_plus};

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_imm(in_imm),
    .in_pc_plus(in_pc_plus), .in_wb_sel(in_wb_sel), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_alu_result(out_alu_result), .out_mem_data(out_mem_data),
    .out_imm(out_imm), .out_pc_plus(out_pc_plus), .out_wb_sel(out_wb_sel),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .fwd_a_hit(fwd_a_hit),
    .fwd_b_hit(fwd_b_hit), .retired_count(retired_count), .bubble_count(bubble_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] imm, input logic [15:0] pc, input logic [1:0] sel,
                       input logic [3:0] rd, input logic rw);
    in_valid = v; in_alu_result = alu; in_mem_data = mem; in_imm = imm;
    in_pc_plus = pc; in_wb_sel = sel; in_rd = rd; in_reg_write = rw;
  endtask

  task automatic test_reset();
    logic [135:0] exp_all;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; src_a = 4'd0; src_b = 4'd0;
    drive(1'b1, 16'hAAAA, 16'h5555, 16'h1111, 16'h2222, 2'b11, 4'd7, 1'b1);
    tick(); tick();
    exp_all = '0;
    if ({obs, retired_count, bubble_count} !== exp_all)
      $display("FAIL reset_state: got %h expected %h", {obs, retired_count, bubble_count}, exp_all);
    else n_pass++;
    n_total++;
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [71:0] exp;
    drive(1'b1, 16'h1234, 16'hBEEF, 16'h0007, 16'h0041, 2'b01, 4'd5, 1'b1);
    tick();
    exp = {1'b1, 1'b1, 2'b01, 4'd5, 16'h1234, 16'hBEEF, 16'h0007, 16'h0041};
    if (obs !== exp) $display("FAIL load_fields: got %h expected %h", obs, exp);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_stall();
    logic [71:0] exp;
    exp = {1'b1, 1'b1, 2'b01, 4'd5, 16'h1234, 16'hBEEF, 16'h0007, 16'h0041};
    stall = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hBEEF, 16'h0007, 16'h0041, 2'b01, 4'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs !== exp) $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp);
      else n_pass++;
      n_total++;
    end
    stall = 1'b0;
    tick();
    exp = {1'b1, 1'b1, 2'b01, 4'd9, 16'hFFFF, 16'hBEEF, 16'h0007, 16'h0041};
    if (obs !== exp) $display("FAIL stall_release: got %h expected %h", obs, exp);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_flush();
    logic [71:0] exp;
    stall = 1'b1; flush = 1'b1;
    tick();
    exp = '0;
    if (obs !== exp) $display("FAIL flush_over_stall: got %h expected %h", obs, exp);
    else n_pass++;
    n_total++;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_r0();
    drive(1'b1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 2'b00, 4'd0, 1'b1);
    src_a = 4'd0; src_b = 4'd0;
    tick();
    if ({out_valid, out_reg_write, fwd_a_hit, fwd_b_hit} !== 4'b1000)
      $display("FAIL r0_suppress: got %b expected %b",
               {out_valid, out_reg_write, fwd_a_hit, fwd_b_hit}, 4'b1000);
    else n_pass++;
    n_total++;
    drive(1'b1, 16'h0033, 16'h0000, 16'h0000, 16'h0000, 2'b00, 4'd3, 1'b1);
    src_a = 4'd3; src_b = 4'd3;
    tick();
    if ({out_reg_write, fwd_a_hit, fwd_b_hit} !== 3'b111)
      $display("FAIL fwd_both: got %b expected %b", {out_reg_write, fwd_a_hit, fwd_b_hit}, 3'b111);
    else n_pass++;
    n_total++;
    src_b = 4'd2;
    #1;
    if ({fwd_a_hit, fwd_b_hit} !== 2'b10)
      $display("FAIL fwd_b_miss: got %b expected %b", {fwd_a_hit, fwd_b_hit}, 2'b10);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_bubble_input();
    drive(1'b0, 16'h4444, 16'h4444, 16'h4444, 16'h4444, 2'b10, 4'd4, 1'b1);
    src_a = 4'd4; src_b = 4'd4;
    tick();
    if ({obs, fwd_a_hit, fwd_b_hit} !== 74'd0)
      $display("FAIL bubble_input: got %h expected %h", {obs, fwd_a_hit, fwd_b_hit}, 74'd0);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_sel_pc_no_write();
    logic [71:0] exp;
    drive(1'b1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 2'b11, 4'd15, 1'b0);
    src_a = 4'd15; src_b = 4'd1;
    tick();
    exp = {1'b1, 1'b0, 2'b11, 4'd15, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D};
    if ({obs, fwd_a_hit} !== {exp, 1'b0})
      $display("FAIL sel11_nowrite: got %h expected %h", {obs, fwd_a_hit}, {exp, 1'b0});
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 16'h7777, 16'h7777, 16'h7777, 16'h7777, 2'b01, 4'd6, 1'b1);
    tick();
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    tick();
    if ({obs, retired_count, bubble_count} !== 136'd0)
      $display("FAIL reset_mid_stall: got %h expected %h", {obs, retired_count, bubble_count}, 136'd0);
    else n_pass++;
    n_total++;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_perf();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 4'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'h0010, 16'h0, 16'h0, 16'h0, 2'b00, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0; in_valid = 1'b0;
    tick(); tick();
`ifdef MEMWB_PERF_EN
    if ({retired_count, bubble_count} !== {32'd5, 32'd2})
      $display("FAIL perf_counts: got %0d/%0d expected 5/2", retired_count, bubble_count);
    else n_pass++;
    n_total++;
    force dut.r_retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired_count;
    in_valid = 1'b1;
    tick(); tick();
    if ({retired_count, bubble_count} !== {32'hFFFF_FFFF, 32'd3})
      $display("FAIL perf_saturate: got %h/%h expected ffffffff/00000003", retired_count, bubble_count);
    else n_pass++;
    n_total++;
`else
    if ({retired_count, bubble_count} !== 64'd0)
      $display("FAIL perf_tied_off: got %h/%h expected 0/0", retired_count, bubble_count);
    else n_pass++;
    n_total++;
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_r0();
    test_bubble_input();
    test_sel_pc_no_write();
    test_reset_mid_stall();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register of the 16-bit pipelined core.
- Captures the four writeback candidates (ALU result, memory load data, immediate, PC+1), the 2-bit writeback select, destination register and write-enable at the end of MEM.
- Presents them registered to the writeback select mux and register-file write port.
- Supports stall (hold), flush (bubble insertion), and combinational forwarding-hit flags for the hazard/forwarding unit.

Parameters:
DATA_W, 16, width of every data path
REG_AW, 4, register address width (16 architectural registers)
R0_ZERO, 1, when 1 register 0 is never written and never reported as a forwarding hit
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold current contents
flush  in  1  replace next contents with a bubble
in_valid  in  1  MEM stage holds a real instruction
in_alu_result  in  DATA_W  ALU result from MEM
in_mem_data  in  DATA_W  data-memory read data
in_imm  in  DATA_W  extended immediate
in_pc_plus  in  DATA_W  PC+1 (link value)
in_wb_sel  in  2  writeback select: 00 ALU, 01 mem, 10 imm, 11 PC+1
in_rd  in  REG_AW  destination register
in_reg_write  in  1  instruction writes rd
src_a  in  REG_AW  decode-stage source A address
src_b  in  REG_AW  decode-stage source B address
out_valid  out  1  WB holds a real instruction
out_alu_result  out  DATA_W  registered in_alu_result (mux data0)
out_mem_data  out  DATA_W  registered in_mem_data (mux data1)
out_imm  out  DATA_W  registered in_imm (mux data2)
out_pc_plus  out  DATA_W  registered in_pc_plus (mux data3)
out_wb_sel  out  2  registered select to mux
out_rd  out  REG_AW  register-file write address
out_reg_write  out  1  register-file write enable
fwd_a_hit  out  1  WB result must forward to source A
fwd_b_hit  out  1  WB result must forward to source B
retired_count  out  CNT_W  instructions retired (optional feature)
bubble_count  out  CNT_W  bubble cycles (optional feature)

Behaviour:
- Reset: all out_* data fields 0, out_wb_sel 00, out_rd 0, out_valid 0, out_reg_write 0, both counters 0. Reset applied mid-stall or mid-flush still clears everything on that edge.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority per edge: rst > flush > stall > load.
- flush=1: bubble loaded. out_valid=0, out_reg_write=0, all data fields, out_wb_sel and out_rd set to 0. flush overrides a simultaneous stall.
- stall=1, flush=0: every output register holds its value. A held valid instruction keeps out_reg_write asserted; the repeated register-file write of the same value is accepted.
- Load:
  - out_valid <= in_valid.
  - out_reg_write <= in_valid & in_reg_write & ~(R0_ZERO & in_rd==0).
  - If in_valid=0, load a bubble exactly as for flush.
  - Otherwise load all data fields, out_wb_sel and out_rd from inputs.
- Forwarding (combinational from registered state plus src_x):
  - fwd_x_hit = out_valid & out_reg_write & (out_rd==src_x) & ~(R0_ZERO & src_x==0).
  - Both hits may assert together when src_a==src_b.
- out_wb_sel 11 is a legal value and selects PC+1 downstream; no value is illegal.

Optional Feature:
- Macro: MEMWB_PERF_EN.
- Defined:
  - retired_count increments on every edge where rst=0, stall=0 and out_valid=1 (instruction leaves WB).
  - bubble_count increments on every edge where rst=0, stall=0 and out_valid=0.
  - Both saturate at all-ones; neither wraps.
  - Both are cleared only by rst.
- Not defined: no counter registers; retired_count and bubble_count are tied to 0; ports remain for interface stability.

Test Plan:
- Reset then load: rst for 2 cycles -> all outputs 0. Then load in_valid=1, alu=0x1234, mem=0xBEEF, imm=0x0007, pc=0x0041, sel=01, rd=5, reg_write=1 -> next cycle outputs equal those values, out_valid=1, out_reg_write=1.
- Stall hold: with the above loaded, stall=1 for 3 cycles while inputs change to alu=0xFFFF, rd=9 -> outputs unchanged. Release stall -> new values appear one cycle later.
- Flush vs stall: stall=1 and flush=1 together with valid contents -> next cycle out_valid=0, out_reg_write=0, all data 0.
- R0 suppression: load rd=0, reg_write=1, valid=1, with src_a=0 -> out_reg_write=0 and fwd_a_hit=0. Then load rd=3, src_a=3, src_b=3 -> fwd_a_hit=1 and fwd_b_hit=1.
- Bubble input: in_valid=0, in_reg_write=1, rd=4, src_a=4 -> out_valid=0, out_reg_write=0, fwd_a_hit=0.
- Perf (MEMWB_PERF_EN): 5 valid loads, 2 bubbles, 3 stalled cycles with valid held -> retired_count=5, bubble_count=2. Force a counter to 0xFFFFFFFF, add one more retire -> value stays 0xFFFFFFFF.
